sram_arbiter: RTL

- Shares the single external 16-bit async SRAM between two requesters.
- Port 0 is the flash boot copy engine; port 1 is the CPU memory interface.
- Owns the SRAM strobe sequencing (cs_n/rd_n/wr_n timing, address/data hold), so requesters see a simple req/gnt/ack handshake.
- Sits between the boot loader / CPU and the top-level SRAM pins.

---
 rtl/sram_arbiter_if.sv | 47 ++++
 rtl/sram_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// Two-requester req/gnt/ack bus plus the async SRAM pin group, shared by the
// arbiter (slave side) and whatever drives the requests and models the SRAM (master side).
interface sram_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic              sram_cs_n;
    logic              sram_rd_n;
    logic              sram_wr_n;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_in;
    logic [DATA_W-1:0] sram_out;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_ack, m1_rdata,
        output sram_cs_n, sram_rd_n, sram_wr_n, sram_addr, sram_in,
        input  sram_out
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_ack, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_ack, m1_rdata,
        input  sram_cs_n, sram_rd_n, sram_wr_n, sram_addr, sram_in,
        output sram_out
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for a single async 16-bit SRAM.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority (m0 wins).
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            state_reg;
    logic [3:0]        cnt_reg;
    logic              owner_reg;
    logic              we_reg;
    logic              last_served_reg;
    logic              cs_n_reg;
    logic              rd_n_reg;
    logic              wr_n_reg;
    logic [ADDR_W-1:0] sram_addr_reg;
    logic [DATA_W-1:0] sram_in_reg;

    logic [1:0]        req_vec;
    logic              grant_valid;
    logic              grant_port;
    logic [1:0]        gnt_vec;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              last_access;
    logic [1:0]        ack_vec;
    logic [DATA_W-1:0] rdata_arr [2];

    assign req_vec     = {bus.m1_req, bus.m0_req};
    assign last_access = (state_reg == ACCESS) && (cnt_reg == 4'd0);

    always_comb begin
        grant_port = 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        if (req_vec == 2'b11)
            grant_port = ~last_served_reg;
        else
            grant_port = req_vec[1];
`else
        grant_port = ~req_vec[0];
`endif
        grant_valid = (state_reg == IDLE) && (req_vec != 2'b00);
    end

    assign sel_we    = grant_port ? bus.m1_we    : bus.m0_we;
    assign sel_addr  = grant_port ? bus.m1_addr  : bus.m0_addr;
    assign sel_wdata = grant_port ? bus.m1_wdata : bus.m0_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= 4'd0;
            owner_reg       <= 1'b0;
            we_reg          <= 1'b0;
            last_served_reg <= 1'b1;
            cs_n_reg        <= 1'b1;
            rd_n_reg        <= 1'b1;
            wr_n_reg        <= 1'b1;
            sram_addr_reg   <= '0;
            sram_in_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        owner_reg       <= grant_port;
                        last_served_reg <= grant_port;
                        we_reg          <= sel_we;
                        sram_addr_reg   <= sel_addr;
                        sram_in_reg     <= sel_wdata;
                        cs_n_reg        <= 1'b0;
                        rd_n_reg        <= sel_we;
                        wr_n_reg        <= ~sel_we;
                        cnt_reg         <= CNT_INIT;
                        state_reg       <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Strobes rise together; addr/data stay put through DONE for hold time.
                    if (cnt_reg == 4'd0) begin
                        cs_n_reg  <= 1'b1;
                        rd_n_reg  <= 1'b1;
                        wr_n_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic              ack_reg;
            logic [DATA_W-1:0] rdata_reg;
            logic              mine;

            assign mine = last_access && (owner_reg == 1'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    ack_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    ack_reg <= mine;
                    if (mine && !we_reg)
                        rdata_reg <= bus.sram_out;
                end
            end

            assign gnt_vec[gi]   = grant_valid && (grant_port == 1'(gi));
            assign ack_vec[gi]   = ack_reg;
            assign rdata_arr[gi] = rdata_reg;
        end
    endgenerate

    assign bus.m0_gnt   = gnt_vec[0];
    assign bus.m1_gnt   = gnt_vec[1];
    assign bus.m0_ack   = ack_vec[0];
    assign bus.m1_ack   = ack_vec[1];
    assign bus.m0_rdata = rdata_arr[0];
    assign bus.m1_rdata = rdata_arr[1];

    assign bus.sram_cs_n = cs_n_reg;
    assign bus.sram_rd_n = rd_n_reg;
    assign bus.sram_wr_n = wr_n_reg;
    assign bus.sram_addr = sram_addr_reg;
    assign bus.sram_in   = sram_in_reg;
endmodule
